// File: rtl/fp_pkg.sv
// Shared FPU definitions: significand/exponent widths, the significand
// multiplier's state encoding, and the 2-bit FPU operation codes used by
// the control unit.
package fp_pkg;

    localparam int MANT_W = 24;          // significand width, hidden bit included
    localparam int PROD_W = 2 * MANT_W;  // full significand product width
    localparam int EXP_W  = 8;           // single-precision exponent width

    // Significand multiplier sequencing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // FPU operation codes, shared with the control unit.
    typedef enum logic [1:0] {
        OP_SUM = 2'b00,
        OP_MUL = 2'b01
    } fpu_op_t;

endpackage

// File: rtl/fp_mul_normalizer.sv
// Combinational normalizer for a raw significand product.
// Ports: product (in) -> prod_hi (exponent +1 needed), mant_out (normalized
//        significand), guard, round_bit, sticky (rounding bits for the rounder).
module fp_mul_normalizer #(
    parameter int MANT_W = fp_pkg::MANT_W,
    localparam int PROD_W = 2 * MANT_W
) (
    input  logic [PROD_W-1:0] product,
    output logic              prod_hi,
    output logic [MANT_W-1:0] mant_out,
    output logic              guard,
    output logic              round_bit,
    output logic              sticky
);

    // The product of two [1,2) significands lies in [1,4): when the top bit
    // is set the binary point moved one place left, so take the window one
    // bit higher and let the exponent absorb the +1.
    assign prod_hi = product[PROD_W-1];

    always_comb begin
        if (prod_hi) begin
            mant_out  = product[PROD_W-1:MANT_W];
            guard     = product[MANT_W-1];
            round_bit = product[MANT_W-2];
            sticky    = |product[MANT_W-3:0];
        end else begin
            mant_out  = product[PROD_W-2:MANT_W-1];
            guard     = product[MANT_W-2];
            round_bit = product[MANT_W-3];
            sticky    = |product[MANT_W-4:0];
        end
    end

endmodule

// File: rtl/fp_mantissa_multiplier.sv
// Sequential shift-add multiplier for two significands (hidden bit included),
// producing the raw product plus its normalized form and guard/round/sticky.
// Ports: clk, reset (sync, active-high); start (sampled in IDLE/DONE),
//        mant_a/mant_b (captured on accept); busy, done (level until next
//        accepted start), product, prod_hi, mant_out, guard, round_bit, sticky.
// Build option FP_MUL_RADIX4_EN: retire two multiplier bits per step
// (MANT_W/2 cycles) instead of one (MANT_W cycles); results are identical.
module fp_mantissa_multiplier #(
    parameter int MANT_W = fp_pkg::MANT_W,
    localparam int PROD_W = 2 * MANT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product,
    output logic              prod_hi,
    output logic [MANT_W-1:0] mant_out,
    output logic              guard,
    output logic              round_bit,
    output logic              sticky
);

    localparam int CNT_W = $clog2(MANT_W + 1);

`ifdef FP_MUL_RADIX4_EN
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(MANT_W / 2);
`else
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(MANT_W);
`endif

    fp_pkg::mul_state_t state, state_next;

    logic [MANT_W-1:0] mcand;
    logic [PROD_W-1:0] acc;       // upper half: partial sum, lower half: unconsumed multiplier bits
    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] product_r;
    logic [CNT_W-1:0]  counter;
    logic              accept;
    logic              last_step;

    assign accept    = start && (state == fp_pkg::IDLE || state == fp_pkg::DONE);
    assign last_step = (state == fp_pkg::BUSY) && (counter == CNT_W'(1));

    // One iteration of the shift-add recurrence.
`ifdef FP_MUL_RADIX4_EN
    // Upper half plus at most 3*mcand stays below 2^(MANT_W+2).
    logic [MANT_W+1:0] mcand3;
    logic [MANT_W+1:0] addend;
    logic [MANT_W+1:0] sum;

    always_comb begin
        case (acc[1:0])
            2'b00:   addend = '0;
            2'b01:   addend = {2'b00, mcand};
            2'b10:   addend = {1'b0, mcand, 1'b0};
            default: addend = mcand3;
        endcase
        sum      = {2'b00, acc[PROD_W-1:MANT_W]} + addend;
        acc_next = {sum, acc[MANT_W-1:2]};
    end
`else
    logic [MANT_W:0] sum;

    always_comb begin
        sum      = {1'b0, acc[PROD_W-1:MANT_W]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[MANT_W-1:1]};
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= fp_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is ignored while iterating.
    always_comb begin
        state_next = state;
        case (state)
            fp_pkg::IDLE: if (start)     state_next = fp_pkg::BUSY;
            fp_pkg::BUSY: if (last_step) state_next = fp_pkg::DONE;
            fp_pkg::DONE: if (start)     state_next = fp_pkg::BUSY;
            default:                     state_next = fp_pkg::IDLE;
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            fp_pkg::BUSY: busy = 1'b1;
            fp_pkg::DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath. product only updates on the final step so it stays stable
    // through DONE and across a later start until the next result lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand     <= '0;
            acc       <= '0;
            counter   <= '0;
            product_r <= '0;
`ifdef FP_MUL_RADIX4_EN
            mcand3    <= '0;
`endif
        end else if (accept) begin
            mcand   <= mant_a;
            acc     <= {{MANT_W{1'b0}}, mant_b};
            counter <= STEPS;
`ifdef FP_MUL_RADIX4_EN
            mcand3  <= {2'b00, mant_a} + {1'b0, mant_a, 1'b0};
`endif
        end else if (state == fp_pkg::BUSY) begin
            acc     <= acc_next;
            counter <= counter - CNT_W'(1);
            if (last_step) begin
                product_r <= acc_next;
            end
        end
    end

    assign product = product_r;

    fp_mul_normalizer #(.MANT_W(MANT_W)) u_norm (
        .product   (product_r),
        .prod_hi   (prod_hi),
        .mant_out  (mant_out),
        .guard     (guard),
        .round_bit (round_bit),
        .sticky    (sticky)
    );

endmodule

// File: tb/tb_fp_mantissa_multiplier.sv
// Testbench for fp_mantissa_multiplier: table of operand pairs with expected
// product and normalization, applied through a scoreboard queue, plus
// sequences for mid-operation restart attempts and reset aborts.
module tb_fp_mantissa_multiplier;

`ifdef FP_MUL_RADIX4_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 24;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        busy;
    logic        done;
    logic [47:0] product;
    logic        prod_hi;
    logic [23:0] mant_out;
    logic        guard;
    logic        round_bit;
    logic        sticky;

    fp_mantissa_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mant_a    (mant_a),
        .mant_b    (mant_b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .prod_hi   (prod_hi),
        .mant_out  (mant_out),
        .guard     (guard),
        .round_bit (round_bit),
        .sticky    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] prod;
        logic        hi;
        logic [23:0] mant;
        logic        g;
        logic        r;
        logic        s;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: exact integer product, then pick the 24-bit window.
    function automatic vec_t model(input logic [23:0] a, input logic [23:0] b);
        vec_t v;
        logic [63:0] p;
        p      = 64'(a) * 64'(b);
        v.a    = a;
        v.b    = b;
        v.prod = p[47:0];
        v.hi   = p[47];
        if (p[47]) begin
            v.mant = p[47:24];
            v.g    = p[23];
            v.r    = p[22];
            v.s    = (p[21:0] != 22'd0);
        end else begin
            v.mant = p[46:23];
            v.g    = p[22];
            v.r    = p[21];
            v.s    = (p[20:0] != 21'd0);
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p,
                                input logic hi, input logic [23:0] m,
                                input logic g, input logic r, input logic s);
        vec_t v;
        v.a = a; v.b = b; v.prod = p; v.hi = hi; v.mant = m; v.g = g; v.r = r; v.s = s;
        return v;
    endfunction

    task automatic compare_result(input string tag);
        vec_t e;
        e = sb.pop_front();
        check({tag, " product"},   product,   e.prod);
        check({tag, " prod_hi"},   prod_hi,   e.hi);
        check({tag, " mant_out"},  mant_out,  e.mant);
        check({tag, " guard"},     guard,     e.g);
        check({tag, " round_bit"}, round_bit, e.r);
        check({tag, " sticky"},    sticky,    e.s);
    endtask

    // Called at a negedge. Drives start for one cycle (back-to-back from DONE
    // when the previous op just finished), scrambles the operand inputs
    // after the accept edge, optionally re-pulses start at poke_at while busy,
    // and waits (bounded) for done.
    task automatic run_op(input vec_t v, input int poke_at, input string tag);
        int n;
        bit got;
        mant_a = v.a;
        mant_b = v.b;
        start  = 1'b1;
        sb.push_back(v);
        n   = 0;
        got = 0;
        while (!got && n < LAT + 10) begin
            @(negedge clk);
            n++;
            start  = (poke_at != 0 && n == poke_at);
            mant_a = 24'($urandom);
            mant_b = 24'($urandom);
            if (n == 1) begin
                check({tag, " busy after accept"}, busy, 1);
                check({tag, " done after accept"}, done, 0);
            end
            if (done) got = 1;
        end
        start = 1'b0;
        check({tag, " done seen"}, got, 1);
        if (got) begin
            check({tag, " latency"}, n - 1, LAT);
            compare_result(tag);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mant_a = '0;
        mant_b = '0;

        vecs[0] = mk(24'h800000, 24'h800000, 48'h400000000000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 24'h900000, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, 1'b1);
        vecs[3] = model(24'h000000, 24'hABCDEF);
        vecs[4] = model(24'h800000, 24'hFFFFFF);
        vecs[5] = model(24'h000001, 24'h000003);
        vecs[6] = model(24'hAAAAAA, 24'h555555);
        for (int i = 7; i < 10; i++) begin
            vecs[i] = model(24'($urandom) | 24'h800000, 24'($urandom) | 24'h800000);
        end

        repeat (3) @(negedge clk);
        check("reset busy",     busy,     0);
        check("reset done",     done,     0);
        check("reset product",  product,  0);
        check("reset prod_hi",  prod_hi,  0);
        check("reset mant_out", mant_out, 0);
        check("reset grs",      {guard, round_bit, sticky}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle no start busy", busy, 0);

        // Table: consecutive ops, each started the cycle done is seen.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // DONE with no start: result held.
        repeat (3) @(negedge clk);
        check("hold done",    done,    1);
        check("hold product", product, vecs[9].prod);

        // start re-pulsed mid-BUSY with other operands: ignored.
        mant_a = 24'h123456;
        run_op(vecs[1], 5, "restart ignored");

        // Reset after 10 busy cycles aborts with no residue.
        mant_a = 24'hFFFFFF;
        mant_b = 24'hFFFFFF;
        start  = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-abort busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy",     busy,     0);
        check("abort done",     done,     0);
        check("abort product",  product,  0);
        check("abort mant_out", mant_out, 0);
        @(negedge clk);
        check("abort stays idle", busy, 0);

        run_op(vecs[6], 0, "after abort");
        run_op(vecs[2], 0, "final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
